life_step_engine: RTL and testbench

//  Reader side of the cell-board port. On each rising edge of the step request
//  (change_state from the evolve controller), it scans the board row by row

---
 rtl/life_step_engine_pkg.sv | 25 ++
 rtl/life_cell_rule.sv | 14 +
 rtl/life_step_engine.sv | 206 ++++++++++++++++++++
 tb/tb_life_step_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/life_step_engine_pkg.sv
// Shared types for the Conway step engine: state encodings, address width and the neighbour counter.
// Build option: define LIFE_TORUS_EN for a board that wraps in both axes.
package life_step_engine_pkg;

  localparam int ADDR_WIDTH   = 8;
  localparam int LIFE_STATE_W = 3;

  typedef enum logic [LIFE_STATE_W-1:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    LOAD  = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } life_state_t;

  function automatic logic [3:0] count_live(input logic [7:0] bits);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: takes the 3x3 neighbourhood (centre at bit 4) and returns the next state.
module life_cell_rule
  import life_step_engine_pkg::*;
(
  input  logic [8:0] hood,
  output logic       next_cell
);

  logic [3:0] live_n;

  assign live_n    = count_live({hood[8:5], hood[3:0]});
  assign next_cell = (live_n == 4'd3) | (hood[4] & (live_n == 4'd2));

endmodule

// File: rtl/life_step_engine.sv
// Computes one Conway generation in place by streaming rows through prev/cur/nxt buffers.
// Build option: LIFE_TORUS_EN wraps the board; without it, cells off the board are dead.
module life_step_engine
  import life_step_engine_pkg::*;
#(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] rAddrR,
  output logic [ADDR_WIDTH-1:0] rAddrC,
  input  logic                  read_data,
  output logic [ADDR_WIDTH-1:0] wAddrR,
  output logic [ADDR_WIDTH-1:0] wAddrC,
  output logic                  write_en,
  output logic                  write_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           gen_count
);

  localparam int COL_W = $clog2(MAP_WIDTH);
  localparam int CNT_W = $clog2(MAP_WIDTH + 1);
  localparam int ROW_W = $clog2(MAP_HEIGHT);
  localparam logic [CNT_W-1:0] READ_END = CNT_W'(MAP_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAP_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAP_HEIGHT - 1);

  life_state_t state, state_next;

  logic [CNT_W-1:0]     cnt;
  logic [COL_W-1:0]     col, col_m1, col_p1;
  logic [ROW_W-1:0]     row;
  logic [MAP_WIDTH-1:0] prev_row, cur_row, nxt_row;
  logic                 step_q, accept, read_end, last_col, last_row, prime_done;
  logic                 left_ok, right_ok;
  logic [8:0]           hood;
  logic                 rule_out;

`ifdef LIFE_TORUS_EN
  logic [MAP_WIDTH-1:0] row0_buf;
  logic                 prime_phase;
  logic [COL_W-1:0]     left_idx, right_idx;
  assign prime_done = read_end & prime_phase;
  assign left_idx   = left_ok ? col_m1 : LAST_COL;
  assign right_idx  = right_ok ? col_p1 : '0;
`else
  assign prime_done = read_end;
`endif

  // Read states spend W+1 clocks: cnt issues columns 0..W-1 and lands each value one clock later.
  assign col      = cnt[COL_W-1:0];
  assign col_m1   = col - 1'b1;
  assign col_p1   = col + 1'b1;
  assign read_end = (cnt == READ_END);
  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);
  assign left_ok  = (col != '0);
  assign right_ok = ~last_col;
  assign accept   = step & ~step_q & mode & (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PRIME;
      PRIME:   if (prime_done) state_next = LOAD;
      LOAD:    if (last_row || read_end) state_next = EVAL;
      EVAL:    if (last_col) state_next = last_row ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q    <= 1'b0;
      cnt       <= '0;
      row       <= '0;
      prev_row  <= '0;
      cur_row   <= '0;
      nxt_row   <= '0;
      gen_count <= 16'd0;
`ifdef LIFE_TORUS_EN
      row0_buf    <= '0;
      prime_phase <= 1'b0;
`endif
    end else begin
      step_q <= step;
      case (state)
        IDLE: begin
          cnt <= '0;
          row <= '0;
`ifdef LIFE_TORUS_EN
          prime_phase <= 1'b0;
`endif
        end
        PRIME: begin
`ifdef LIFE_TORUS_EN
          if (cnt != '0) begin
            if (prime_phase) begin
              cur_row[col_m1]  <= read_data;
              row0_buf[col_m1] <= read_data;
            end else begin
              prev_row[col_m1] <= read_data;
            end
          end
          if (read_end) prime_phase <= 1'b1;
`else
          prev_row <= '0;
          if (cnt != '0) cur_row[col_m1] <= read_data;
`endif
          cnt <= read_end ? '0 : cnt + 1'b1;
        end
        LOAD: begin
          if (last_row) begin
`ifdef LIFE_TORUS_EN
            nxt_row <= row0_buf;
`else
            nxt_row <= '0;
`endif
            cnt <= '0;
          end else begin
            if (cnt != '0) nxt_row[col_m1] <= read_data;
            cnt <= read_end ? '0 : cnt + 1'b1;
          end
        end
        EVAL: begin
          if (last_col) begin
            cnt      <= '0;
            prev_row <= cur_row;
            cur_row  <= nxt_row;
            if (!last_row) row <= row + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    gen_count <= gen_count + 16'd1;
        default: ;
      endcase
    end
  end

  // Column mux feeding the single rule instance: bit order is left/centre/right per row, top row first.
  always_comb begin
`ifdef LIFE_TORUS_EN
    hood = {prev_row[left_idx], prev_row[col], prev_row[right_idx],
            cur_row[left_idx],  cur_row[col],  cur_row[right_idx],
            nxt_row[left_idx],  nxt_row[col],  nxt_row[right_idx]};
`else
    hood = {left_ok & prev_row[col_m1], prev_row[col], right_ok & prev_row[col_p1],
            left_ok & cur_row[col_m1],  cur_row[col],  right_ok & cur_row[col_p1],
            left_ok & nxt_row[col_m1],  nxt_row[col],  right_ok & nxt_row[col_p1]};
`endif
  end

  life_cell_rule u_rule (
    .hood      (hood),
    .next_cell (rule_out)
  );

  always_comb begin
    rAddrR     = '0;
    rAddrC     = '0;
    wAddrR     = '0;
    wAddrC     = '0;
    write_en   = 1'b0;
    write_data = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      PRIME: begin
        if (!read_end) rAddrC = ADDR_WIDTH'(col);
`ifdef LIFE_TORUS_EN
        rAddrR = prime_phase ? '0 : ADDR_WIDTH'(LAST_ROW);
`endif
      end
      LOAD: begin
        if (!last_row && !read_end) begin
          rAddrR = ADDR_WIDTH'(row + 1'b1);
          rAddrC = ADDR_WIDTH'(col);
        end
      end
      EVAL: begin
        write_en   = 1'b1;
        write_data = rule_out;
        wAddrR     = ADDR_WIDTH'(row);
        wAddrC     = ADDR_WIDTH'(col);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine on an 8x8 board: a 1-clk-latency board memory, a scoreboard fed by an
// independent Life model, and an ordering monitor. Honours LIFE_TORUS_EN like the design.
module tb_life_step_engine;

  logic        clk = 1'b0;
  logic        rst, mode, step, read_data;
  logic [7:0]  rAddrR, rAddrC, wAddrR, wAddrC;
  logic        write_en, write_data, busy, done;
  logic [15:0] gen_count;

`ifdef LIFE_TORUS_EN
  localparam int EXP_LAT = 146;
`else
  localparam int EXP_LAT = 137;
`endif

  typedef struct {
    logic [63:0] board;
    logic [15:0] gen;
    int          lat;
    int          writes;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  logic [15:0] exp_gen = 16'd0;

  logic [63:0] board_mem;
  logic [63:0] load_val;
  logic        load_en;
  logic [7:0]  rows_read;
  int          write_cnt;
  int          violations = 0;
  logic        bad_ctx, bad_order, bad_addr;

  life_step_engine #(.MAP_WIDTH(8), .MAP_HEIGHT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .step       (step),
    .rAddrR     (rAddrR),
    .rAddrC     (rAddrC),
    .read_data  (read_data),
    .wAddrR     (wAddrR),
    .wAddrC     (wAddrC),
    .write_en   (write_en),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  // Board memory with a one-clock read port; cell index is row*8+col.
  always @(posedge clk) begin
    read_data <= board_mem[{rAddrR[2:0], rAddrC[2:0]}];
    if (load_en) board_mem <= load_val;
    else if (write_en) board_mem[{wAddrR[2:0], wAddrC[2:0]}] <= write_data;
  end

  // A row may be written only once the row below it has been fully addressed.
  assign bad_ctx   = write_en & (~busy | done);
  assign bad_order = write_en & (wAddrR[2:0] != 3'd7) & ~rows_read[wAddrR[2:0] + 3'd1];
  assign bad_addr  = |{rAddrR[7:3], rAddrC[7:3], wAddrR[7:3], wAddrC[7:3]};

  always @(posedge clk) begin
    if (!busy) begin
      rows_read <= 8'd0;
      write_cnt <= 0;
    end else begin
      if (rAddrC[2:0] == 3'd7) rows_read[rAddrR[2:0]] <= 1'b1;
      if (write_en) write_cnt <= write_cnt + 1;
    end
    if (rst) violations <= violations + int'(bad_ctx) + int'(bad_order) + int'(bad_addr);
  end

  function automatic logic [63:0] next_gen(input logic [63:0] b);
    logic [63:0] nb;
    int n, rr, cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef LIFE_TORUS_EN
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
              n += int'(b[rr*8+cc]);
`else
              if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) n += int'(b[rr*8+cc]);
`endif
            end
          end
        end
        nb[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_board(input logic [63:0] b);
    @(negedge clk);
    load_val = b;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Pushes the model's prediction, drives one step edge, then pops and compares when done pulses.
  task automatic apply_stimulus(input string tag, input int extra_edge_at, input int mode_drop_at);
    exp_t e;
    int   lat;
    int   tries;
    int   writes;
    e.board = next_gen(board_mem);
    exp_gen = exp_gen + 16'd1;
    e.gen    = exp_gen;
    e.lat    = EXP_LAT;
    e.writes = 64;
    sb.push_back(e);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    tries = 0;
    while (!busy && tries < 10) begin
      @(negedge clk);
      tries++;
    end
    step = 1'b0;
    lat = 0;
    if (busy) begin
      while (!done && lat < 1000) begin
        @(negedge clk);
        lat++;
        if (lat == extra_edge_at) step = 1'b1;
        if (lat == extra_edge_at + 2) step = 1'b0;
        if (lat == mode_drop_at) mode = 1'b0;
      end
    end
    writes = write_cnt;
    mode = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    check_output({tag, "_board"}, board_mem, e.board);
    check_output({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check_output({tag, "_writes"}, 64'(writes), 64'(e.writes));
    check_output({tag, "_gen"}, 64'(gen_count), 64'(e.gen));
    check_output({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] blinker, blinker_next, block, glider, glider_end;
    int busy_seen;
    int tries;
    blinker      = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    blinker_next = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    block        = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
    glider       = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);
`ifdef LIFE_TORUS_EN
    glider_end   = glider;
`else
    glider_end   = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);
`endif

    rst = 1'b0; mode = 1'b1; step = 1'b0; load_en = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_write_en", 64'(write_en), 64'd0);
    check_output("reset_write_data", 64'(write_data), 64'd0);
    check_output("reset_gen", 64'(gen_count), 64'd0);
    check_output("reset_raddr", 64'({rAddrR, rAddrC}), 64'd0);
    check_output("reset_waddr", 64'({wAddrR, wAddrC}), 64'd0);
    rst = 1'b1;

    load_board(blinker);
    apply_stimulus("blinker", -1, -1);
    check_output("blinker_const", board_mem, blinker_next);

    load_board(block);
    for (int i = 0; i < 3; i++) apply_stimulus("block", -1, -1);
    check_output("block_const", board_mem, block);

    load_board(glider);
    for (int i = 0; i < 32; i++) apply_stimulus("glider", -1, -1);
    check_output("glider_const", board_mem, glider_end);

    mode = 1'b0;
    @(negedge clk);
    step = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    step = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    check_output("mode0_busy", 64'(busy_seen), 64'd0);
    check_output("mode0_gen", 64'(gen_count), 64'(exp_gen));

    load_board(blinker);
    apply_stimulus("busy_edge", 50, 60);
    repeat (5) @(negedge clk);
    check_output("busy_edge_dropped", 64'(busy), 64'd0);

    load_board(blinker);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    tries = 0;
    while (!busy && tries < 10) begin
      @(negedge clk);
      tries++;
    end
    step = 1'b0;
    repeat (69) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("midreset_busy", 64'(busy), 64'd0);
    check_output("midreset_write_en", 64'(write_en), 64'd0);
    check_output("midreset_gen", 64'(gen_count), 64'd0);
    rst = 1'b1;
    exp_gen = 16'd0;
    apply_stimulus("post_reset", -1, -1);

    check_output("order_violations", 64'(violations), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
